// File: rtl/slab_div_sequencer.sv
// slab_div_sequencer: forms per-axis slab numerators, feeds the shared divider
// one axis per cycle (x, y, z), substitutes saturated t for zero divisors and
// collects the in-order quotients into t_x/t_y/t_z for the slab compare stage.
module slab_div_sequencer #(
    parameter int                 DIV_LATENCY = 28,
    parameter logic signed [23:0] T_MAX       = 24'sh7FFFFF
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] origin_x,
    input  logic [23:0] origin_y,
    input  logic [23:0] origin_z,
    input  logic [23:0] dir_x,
    input  logic [23:0] dir_y,
    input  logic [23:0] dir_z,
    input  logic [23:0] plane_x,
    input  logic [23:0] plane_y,
    input  logic [23:0] plane_z,
    output logic        div_divisor_tvalid,
    output logic        div_dividend_tvalid,
    output logic [23:0] div_divisor,
    output logic [23:0] div_dividend,
    input  logic        div_tvalid,
    input  logic [23:0] div_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] t_x,
    output logic [23:0] t_y,
    output logic [23:0] t_z,
    output logic [2:0]  zero_mask
);

    typedef enum logic [2:0] {DRAIN, IDLE, ISSUE, WAIT, DONE} state_t;

    localparam int CW = $clog2(DIV_LATENCY + 3);

    state_t            state, state_nx;
    logic [CW-1:0]     drain_cnt;
    logic [1:0]        ax;          // axis being issued
    logic [2:0][23:0]  num;         // saturated numerators, [0] = x
    logic [2:0][23:0]  dvs;         // divisors
    logic [2:0][1:0]   tag_q;       // axis tags of issued divides, in order
    logic [1:0]        wr_ptr;      // doubles as issued count
    logic [1:0]        rd_ptr;      // doubles as received count
    logic [2:0][23:0]  t_r;
    logic [2:0]        zmask;
    logic [23:0]       cur_num;
    logic [23:0]       cur_dvs;
    logic              issue_nz;
    logic              accept;
    logic              take_res;

    // 25-bit difference clamped back into the signed 24-bit range
    function automatic logic [23:0] sat24(input logic [23:0] p, input logic [23:0] o);
        logic [24:0] d;
        d = {p[23], p} - {o[23], o};
        if (d[24] != d[23])
            return d[24] ? 24'h800000 : 24'h7FFFFF;
        return d[23:0];
    endfunction

    // operand mux for the axis currently in the issue slot
    always_comb begin
        cur_num = '0;
        cur_dvs = '0;
        case (ax)
            2'd0: begin cur_num = num[0]; cur_dvs = dvs[0]; end
            2'd1: begin cur_num = num[1]; cur_dvs = dvs[1]; end
            2'd2: begin cur_num = num[2]; cur_dvs = dvs[2]; end
            default: ;
        endcase
    end

    assign issue_nz            = (state == ISSUE) && (cur_dvs != '0);
    assign div_divisor_tvalid  = issue_nz;
    assign div_dividend_tvalid = issue_nz;
    assign div_divisor         = issue_nz ? cur_dvs : '0;
    assign div_dividend        = issue_nz ? cur_num : '0;
    assign accept              = (state == IDLE) && in_valid;
    // results outside WAIT (stale ones after a reset) or beyond the tags are dropped
    assign take_res            = (state == WAIT) && div_tvalid && (rd_ptr != wr_ptr);

    assign t_x       = t_r[0];
    assign t_y       = t_r[1];
    assign t_z       = t_r[2];
    assign zero_mask = zmask;

    // state register
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) state <= DRAIN;
        else     state <= state_nx;
    end

    // next-state and handshake outputs
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            DRAIN: if (drain_cnt == CW'(DIV_LATENCY + 1)) state_nx = IDLE;
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = ISSUE;
            end
            ISSUE: if (ax == 2'd2)
                state_nx = ((wr_ptr != 2'd0) || issue_nz) ? WAIT : DONE;
            WAIT: if (take_res && (rd_ptr + 2'd1 == wr_ptr)) state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = DRAIN;
        endcase
    end

    // datapath: drain counter, operand capture, issue bookkeeping, result collection
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            drain_cnt <= '0;
            ax        <= '0;
            num       <= '0;
            dvs       <= '0;
            tag_q     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            t_r       <= '0;
            zmask     <= '0;
        end else begin
            drain_cnt <= (state == DRAIN) ? drain_cnt + CW'(1) : '0;
            if (accept) begin
                num    <= {sat24(plane_z, origin_z), sat24(plane_y, origin_y), sat24(plane_x, origin_x)};
                dvs    <= {dir_z, dir_y, dir_x};
                ax     <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end
            if (state == ISSUE) begin
                ax <= (ax == 2'd2) ? 2'd0 : ax + 2'd1;
                if (cur_dvs != '0) begin
                    tag_q[wr_ptr] <= ax;
                    wr_ptr        <= wr_ptr + 2'd1;
                end else begin
                    t_r[ax]   <= cur_num[23] ? ~T_MAX : T_MAX;
                    zmask[ax] <= 1'b1;
                end
            end
            if (take_res) begin
                t_r[tag_q[rd_ptr]] <= div_result;
                rd_ptr             <= rd_ptr + 2'd1;
            end
            if ((state == DONE) && out_ready) begin
                zmask  <= '0;
                tag_q  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end
        end
    end

endmodule

// File: tb/tb_slab_div_sequencer.sv
// tb_slab_div_sequencer: drives ray/plane transactions into slab_div_sequencer
// with a fixed-latency divider model and checks results, latency and handshakes
// against a plain-arithmetic reference of the slab parameter rules.
module tb_slab_div_sequencer;

    localparam int L = 28;

    logic        sysclk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] origin_x = '0, origin_y = '0, origin_z = '0;
    logic [23:0] dir_x = '0, dir_y = '0, dir_z = '0;
    logic [23:0] plane_x = '0, plane_y = '0, plane_z = '0;
    logic        div_divisor_tvalid, div_dividend_tvalid;
    logic [23:0] div_divisor, div_dividend;
    logic        div_tvalid;
    logic [23:0] div_result;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] t_x, t_y, t_z;
    logic [2:0]  zero_mask;

    int errors = 0;
    int checks = 0;

    slab_div_sequencer #(.DIV_LATENCY(L)) dut (
        .sysclk(sysclk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .origin_x(origin_x), .origin_y(origin_y), .origin_z(origin_z),
        .dir_x(dir_x), .dir_y(dir_y), .dir_z(dir_z),
        .plane_x(plane_x), .plane_y(plane_y), .plane_z(plane_z),
        .div_divisor_tvalid(div_divisor_tvalid), .div_dividend_tvalid(div_dividend_tvalid),
        .div_divisor(div_divisor), .div_dividend(div_dividend),
        .div_tvalid(div_tvalid), .div_result(div_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .t_x(t_x), .t_y(t_y), .t_z(t_z), .zero_mask(zero_mask)
    );

    always #5 sysclk = ~sysclk;

    // 12.12 quotient, truncated toward zero
    function automatic logic [23:0] divq(input logic [23:0] n, input logic [23:0] d);
        longint a, b;
        if (d == 24'h0) return 24'h0;
        a = longint'($signed(n));
        b = longint'($signed(d));
        return 24'((a * 4096) / b);
    endfunction

    function automatic logic [23:0] satsub(input logic [23:0] p, input logic [23:0] o);
        longint dd;
        dd = longint'($signed(p)) - longint'($signed(o));
        if (dd > 64'sd8388607)  return 24'h7FFFFF;
        if (dd < -64'sd8388608) return 24'h800000;
        return 24'(dd);
    endfunction

    // divider model: fixed latency, not reset, so in-flight results survive a DUT reset
    logic        pv [L];
    logic [23:0] pr [L];
    initial for (int i = 0; i < L; i++) begin pv[i] = 1'b0; pr[i] = '0; end
    always @(posedge sysclk) begin
        pv[0] <= div_divisor_tvalid;
        pr[0] <= divq(div_dividend, div_divisor);
        for (int i = 1; i < L; i++) begin
            pv[i] <= pv[i-1];
            pr[i] <= pr[i-1];
        end
    end
    assign div_tvalid = pv[L-1];
    assign div_result = pr[L-1];

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // after rst deasserts: in_ready low through the drain, high at cycle L+2
    task automatic wait_drain(input string name);
        bit early = 0, noise = 0;
        for (int k = 1; k < L + 2; k++) begin
            tick();
            if (in_ready) early = 1;
            if (out_valid || div_divisor_tvalid) noise = 1;
        end
        tick();
        checks++;
        if (early || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s drain_ready early=%0d in_ready=%b required rise at cycle %0d", name, early, in_ready, L + 2);
        end
        checks++;
        if (noise) begin
            errors++;
            $display("FAIL %s drain_quiet out_valid/tvalid seen during drain, required none", name);
        end
    endtask

    task automatic check_reset_vals(input string name);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || div_divisor_tvalid !== 1'b0 ||
            div_dividend_tvalid !== 1'b0 || div_divisor !== 24'h0 || div_dividend !== 24'h0) begin
            errors++;
            $display("FAIL %s reset_ctrl in_ready=%b out_valid=%b tv=%b%b div=%h/%h required all 0",
                     name, in_ready, out_valid, div_divisor_tvalid, div_dividend_tvalid, div_dividend, div_divisor);
        end
        checks++;
        if (t_x !== 24'h0 || t_y !== 24'h0 || t_z !== 24'h0 || zero_mask !== 3'b000) begin
            errors++;
            $display("FAIL %s reset_data t=%h,%h,%h mask=%b required 0", name, t_x, t_y, t_z, zero_mask);
        end
    endtask

    // one full transaction; stall = cycles out_ready is held low once out_valid is up
    task automatic do_txn(input string name, input logic [2:0][23:0] o, input logic [2:0][23:0] d,
                          input logic [2:0][23:0] p, input int stall);
        logic [2:0][23:0] et;
        logic [2:0]       em;
        logic [23:0]      exp_div[$];
        logic [23:0]      got_div[$];
        logic [23:0]      n;
        logic [23:0]      sx, sy, sz;
        logic [2:0]       sm;
        int last, lat, cyc, ov_at, k;
        bit bad_op, bad_rdy, bad_hold;
        // reference
        last = -1;
        em = '0;
        for (int a = 0; a < 3; a++) begin
            n = satsub(p[a], o[a]);
            if (d[a] == 24'h0) begin
                et[a] = n[23] ? 24'h800000 : 24'h7FFFFF;
                em[a] = 1'b1;
            end else begin
                et[a] = divq(n, d[a]);
                exp_div.push_back(n);
                last = a;
            end
        end
        lat = (last < 0) ? 4 : (2 + last + L);
        // wait for in_ready, bounded
        k = 0;
        while (!in_ready && k < 200) begin tick(); k++; end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL %s ready_timeout in_ready=%b required 1", name, in_ready);
            return;
        end
        origin_x = o[0]; origin_y = o[1]; origin_z = o[2];
        dir_x = d[0];    dir_y = d[1];    dir_z = d[2];
        plane_x = p[0];  plane_y = p[1];  plane_z = p[2];
        in_valid = 1'b1;
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        cyc = 1; ov_at = -1; bad_op = 0; bad_rdy = 0;
        while (ov_at < 0 && cyc < 200) begin
            if (div_divisor_tvalid) got_div.push_back(div_dividend);
            if (div_divisor_tvalid !== div_dividend_tvalid) bad_op = 1;
            if (!div_divisor_tvalid && (div_divisor !== 24'h0 || div_dividend !== 24'h0)) bad_op = 1;
            if (in_ready) bad_rdy = 1;
            if (out_valid) ov_at = cyc;
            else begin tick(); cyc++; end
        end
        checks++;
        if (ov_at != lat) begin
            errors++;
            $display("FAIL %s latency out_valid at N+%0d required N+%0d", name, ov_at, lat);
        end
        checks++;
        if ({t_z, t_y, t_x} !== et) begin
            errors++;
            $display("FAIL %s t got %h,%h,%h required %h,%h,%h", name, t_x, t_y, t_z, et[0], et[1], et[2]);
        end
        checks++;
        if (zero_mask !== em) begin
            errors++;
            $display("FAIL %s zero_mask got %b required %b", name, zero_mask, em);
        end
        checks++;
        if (got_div != exp_div) begin
            errors++;
            $display("FAIL %s issues got %0d dividends (first %h) required %0d (first %h)", name,
                     got_div.size(), (got_div.size() > 0) ? got_div[0] : 24'h0,
                     exp_div.size(), (exp_div.size() > 0) ? exp_div[0] : 24'h0);
        end
        checks++;
        if (bad_op || bad_rdy) begin
            errors++;
            $display("FAIL %s handshake bad_operands=%0d in_ready_during_txn=%0d required 0,0", name, bad_op, bad_rdy);
        end
        if (stall > 0) begin
            sx = t_x; sy = t_y; sz = t_z; sm = zero_mask;
            bad_hold = 0;
            for (int s = 0; s < stall; s++) begin
                tick();
                if (out_valid !== 1'b1 || in_ready !== 1'b0 || div_divisor_tvalid !== 1'b0 ||
                    t_x !== sx || t_y !== sy || t_z !== sz || zero_mask !== sm) bad_hold = 1;
            end
            checks++;
            if (bad_hold) begin
                errors++;
                $display("FAIL %s backpressure outputs changed or ready/issue during stall, required stable", name);
            end
            out_ready = 1'b1;
        end
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s release in_ready=%b out_valid=%b required 1,0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        check_reset_vals("reset");
        rst = 1'b0;
        wait_drain("reset");
    endtask

    task automatic test_basic();
        do_txn("basic", {24'h0, 24'h0, 24'h0}, {24'hFFF000, 24'h001000, 24'h002000},
               {24'h001000, 24'h002000, 24'h004000}, 0);
    endtask

    task automatic test_zero_divisor();
        do_txn("zero_div", {24'h0, 24'h0, 24'h0}, {24'hFFF000, 24'h000000, 24'h002000},
               {24'h001000, 24'hFFF000, 24'h004000}, 0);
    endtask

    task automatic test_all_zero();
        do_txn("all_zero", {24'h0, 24'h0, 24'h0}, {24'h0, 24'h0, 24'h0},
               {24'h001000, 24'h002000, 24'h004000}, 0);
    endtask

    task automatic test_saturation();
        do_txn("saturation", {24'h000100, 24'h7FF000, 24'h800000}, {24'h001000, 24'h001000, 24'h001000},
               {24'h000200, 24'h800000, 24'h7FFFFF}, 0);
    endtask

    task automatic test_backpressure();
        do_txn("backpressure", {24'h000100, 24'h000200, 24'h000300}, {24'h000800, 24'h0, 24'hFFF800},
               {24'h001100, 24'h000000, 24'h002300}, 10);
    endtask

    // back-to-back random transactions with occasional zero divisors and stalls
    task automatic test_random();
        logic [2:0][23:0] o, d, p;
        for (int t = 0; t < 10; t++) begin
            for (int a = 0; a < 3; a++) begin
                o[a] = 24'($urandom);
                p[a] = 24'($urandom);
                d[a] = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
            end
            do_txn($sformatf("random%0d", t), o, d, p, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0);
        end
    endtask

    task automatic test_reset_mid_wait();
        int k;
        k = 0;
        while (!in_ready && k < 200) begin tick(); k++; end
        origin_x = 24'h0; origin_y = 24'h0; origin_z = 24'h0;
        dir_x = 24'h000400; dir_y = 24'h000800; dir_z = 24'h000C00;
        plane_x = 24'h00A000; plane_y = 24'h00B000; plane_z = 24'h00C000;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check_reset_vals("reset_mid_wait");
        tick();
        rst = 1'b0;
        wait_drain("reset_mid_wait");
        do_txn("after_reset", {24'h000100, 24'h000200, 24'h000300}, {24'h003000, 24'hFFE000, 24'h001800},
               {24'h005100, 24'h000200, 24'hFF0300}, 0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_divisor();
        test_all_zero();
        test_saturation();
        test_backpressure();
        test_random();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/slab_div_sequencer.md
# slab_div_sequencer

Upstream feeder and downstream collector for the shared radix-2 fixed-point divider in the ray–box intersection path. Accepts one ray (origin, direction) plus one slab plane point per transaction and forms the three per-axis numerators `plane - origin`. Issues up to three divides (x, y, z) into the divider and collects the in-order quotients. Presents the slab parameters `t_x`, `t_y`, `t_z` to the slab compare stage. All data is signed 12.12 fixed point, 24 bits wide.

## Interface
- `DIV_LATENCY`, default 28: fixed divider latency in cycles, from a tvalid-high issue to the matching `div_tvalid`.
- `T_MAX`, default 24'sh7FFFFF: substitute result for a zero divisor with numerator ≥ 0. Its negation minus 1 (24'sh800000) is used for numerator < 0.
- `sysclk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  ray/plane transaction valid.
- `in_ready`  out  1  block accepts a transaction; the transfer happens on `in_valid & in_ready`.
- `origin_x`, `origin_y`, `origin_z`  in  24 each  signed 12.12 ray origin.
- `dir_x`, `dir_y`, `dir_z`  in  24 each  signed 12.12 ray direction (divisors).
- `plane_x`, `plane_y`, `plane_z`  in  24 each  signed 12.12 slab plane point.
- `div_divisor_tvalid`, `div_dividend_tvalid`  out  1  divider input valids; always driven identically.
- `div_divisor`, `div_dividend`  out  24  divider operands.
- `div_tvalid`  in  1  divider result valid.
- `div_result`  in  24  signed 12.12 quotient.
- `out_valid`  out  1  `t_x`, `t_y`, `t_z` and `zero_mask` are valid.
- `out_ready`  in  1  consumer accepts the result.
- `t_x`, `t_y`, `t_z`  out  24 each  signed 12.12 slab parameters.
- `zero_mask`  out  3  bit i set means axis i had a zero divisor and its t is substituted; bit 0 is x.

## Operation
- States: `DRAIN`, `IDLE`, `ISSUE`, `WAIT`, `DONE`.
- `DRAIN`: entered on reset. Counts `DIV_LATENCY+2` cycles, then goes to `IDLE`. `div_tvalid` is ignored throughout, which discards results still in the divider from an aborted transaction.
- `IDLE`: `in_ready`=1. On accept:
  - Register the numerators `n_a = sat24(plane_a - origin_a)`. The subtraction is done in 25 bits and clamped to [-2^23, 2^23-1].
  - Register the divisors.
  - Go to `ISSUE`.
- `ISSUE`: exactly 3 cycles, one per axis, in order x, y, z.
  - If `dir_a != 0`: drive the operands with tvalid=1 and push axis index a into a 3-entry in-order tag queue.
  - If `dir_a == 0`: tvalid=0. Write `t_a` = `T_MAX` if `n_a` ≥ 0, else `-T_MAX-1`. Set `zero_mask[a]`.
  - After the z cycle: go to `WAIT` if at least one divide was issued, otherwise to `DONE`.
- `WAIT`: each `div_tvalid` pops the tag queue and writes `div_result` into the tagged `t`. Go to `DONE` when received count == issued count. If `div_tvalid` arrives with the queue empty, drop it and set no state.
- `DONE`: `out_valid`=1 and outputs held stable. On `out_ready` go to `IDLE`. `zero_mask` and the tag queue clear on leaving `DONE`.
- Divider operands are driven to 0 whenever tvalid=0.
- `out_valid` never depends combinationally on `out_ready`. `in_ready` depends on state only.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `div_*_tvalid`=0, `div_divisor`=`div_dividend`=0, `t_x`=`t_y`=`t_z`=0, `zero_mask`=0, state `DRAIN`.
- After `rst` deasserts, `in_ready` rises at cycle `DIV_LATENCY+2`.
- Accept at cycle N: issue cycles are N+1, N+2, N+3. The last result arrives at the last issue cycle + `DIV_LATENCY`. `out_valid` rises the cycle after the last result; with all axes issued that is N+4+`DIV_LATENCY`.
- All divisors zero: `out_valid` at N+4.
- Held `out_ready`=1: `DONE` lasts one cycle, `in_ready` is high the next cycle, and the next accept is one cycle after `out_valid`.
- `rst` asserted in any state: immediate return to `DRAIN` with reset values. A partial result is never presented.
- Throughput: one transaction in flight. No overlap of issue and collect across transactions.

## Test plan
- Basic divide. Origin (0,0,0), plane (0x004000, 0x002000, 0x001000), dir (0x002000, 0x001000, 0xFFF000), bench divider model with L=28 → `t` = (0x002000, 0x002000, 0xFFF000), `zero_mask`=0, `out_valid` at N+32.
- Zero divisor. Inputs as in basic, but `dir_y`=0 and plane_y−origin_y = −0x001000 → `t_y`=0x800000, `zero_mask`=3'b010, exactly two divider issues, `out_valid` at N+32.
- All zero divisors. dir=(0,0,0), numerators positive → `t` all 0x7FFFFF, `zero_mask`=3'b111, no tvalid pulses, `out_valid` at N+4.
- Numerator saturation. plane_x=0x7FFFFF, origin_x=0x800000, dir_x=0x001000 → dividend issued as 0x7FFFFF.
- Backpressure. Hold `out_ready`=0 for 10 cycles in `DONE` → outputs stable, `in_ready`=0, no issue; then `out_ready`=1 → `in_ready`=1 the next cycle.
- Reset mid-`WAIT`. Assert `rst` 5 cycles after issue while the divider model still returns stale results → stale results are ignored. A new transaction after `DRAIN` returns only its own quotients.
